// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit that stalls the pipeline until its result is ready
module ex_muldiv #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic [4:0]        write_addr_i,
  input  logic              flush_i,
  output logic              stall_req_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic [4:0]        write_addr_o
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [2:0] op;
  logic s1, s2;
  logic [DATA_W-1:0] d;
  logic [2*DATA_W-1:0] p, p_nxt, prod;
  logic [CW-1:0] cnt;
  logic last, accept;
  logic sig1, sig2, neg1, neg2, div_zero, div_ovf, special;
  logic [DATA_W-1:0] mag1, mag2, special_res, min_neg, diff, quo, rmd, calc_res;
  logic [DATA_W:0] msum, trial;
  logic fits;
  always_comb begin
    min_neg = {1'b1, {(DATA_W-1){1'b0}}};
    sig1 = ~(op_i == 3'b011 || (op_i[2] && op_i[0]));
    sig2 = sig1 && op_i != 3'b010;
    neg1 = sig1 && reg1_data_i[DATA_W-1];
    neg2 = sig2 && reg2_data_i[DATA_W-1];
    mag1 = neg1 ? -reg1_data_i : reg1_data_i;
    mag2 = neg2 ? -reg2_data_i : reg2_data_i;
    div_zero = op_i[2] && reg2_data_i == '0;
    div_ovf = op_i[2] && !op_i[0] && reg1_data_i == min_neg && &reg2_data_i;
    special = div_zero || div_ovf;
    special_res = div_zero ? (op_i[1] ? reg1_data_i : '1) : (op_i[1] ? '0 : min_neg);
    last = cnt == CW'(DATA_W - 1);
    accept = state == IDLE && start_i && !flush_i;
    msum = {1'b0, p[2*DATA_W-1:DATA_W]} + (p[0] ? {1'b0, d} : '0);
    trial = {p[2*DATA_W-1:DATA_W], p[DATA_W-1]};
    fits = trial >= {1'b0, d};
    diff = trial[DATA_W-1:0] - d;
    p_nxt = op[2] ? {fits ? diff : trial[DATA_W-1:0], p[DATA_W-2:0], fits} : {msum, p[DATA_W-1:1]};
    prod = (s1 ^ s2) ? -p_nxt : p_nxt;
    quo = (s1 ^ s2) ? -p_nxt[DATA_W-1:0] : p_nxt[DATA_W-1:0];
    rmd = s1 ? -p_nxt[2*DATA_W-1:DATA_W] : p_nxt[2*DATA_W-1:DATA_W];
    calc_res = op[2] ? (op[1] ? rmd : quo) : (op[1:0] == 2'b00 ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W]);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = flush_i ? IDLE :
                state == IDLE ? (start_i ? (special ? DONE : CALC) : IDLE) :
                state == CALC ? (last ? DONE : CALC) : IDLE;
  end
  always_comb begin
    busy_o = state != IDLE;
    done_o = state == DONE;
    stall_req_o = (state == IDLE && start_i) || state == CALC;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      d <= '0;
      p <= '0;
      cnt <= '0;
      result_o <= '0;
      write_addr_o <= '0;
    end else begin
      if (accept) begin
        op <= op_i;
        write_addr_o <= write_addr_i;
        s1 <= neg1;
        s2 <= neg2;
        d <= op_i[2] ? mag2 : mag1;
        p <= {{DATA_W{1'b0}}, op_i[2] ? mag1 : mag2};
        cnt <= '0;
        if (special) result_o <= special_res;
      end
      if (state == CALC) begin
        p <= p_nxt;
        cnt <= cnt + 1'b1;
        if (last && !flush_i) result_o <= calc_res;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized and directed self-checking bench for ex_muldiv against an arithmetic model
module tb_ex_muldiv;
  logic clk = 0;
  logic rst = 0;
  logic start_i = 0;
  logic [2:0] op_i = '0;
  logic [31:0] reg1_data_i = '0;
  logic [31:0] reg2_data_i = '0;
  logic [4:0] write_addr_i = '0;
  logic flush_i = 0;
  logic stall_req_o, busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0] write_addr_o;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_hold = '0;
  ex_muldiv #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .write_addr_i(write_addr_i), .flush_i(flush_i),
    .stall_req_o(stall_req_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .write_addr_o(write_addr_o)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic [63:0] m;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    m = '0;
    if (op[2] && b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      3'd0: m = sa * sb;
      3'd1: m = (sa * sb) >>> 32;
      3'd2: m = (sa * ub) >>> 32;
      3'd3: m = (ua * ub) >> 32;
      3'd4: m = sa / sb;
      3'd5: m = ua / ub;
      3'd6: m = sa % sb;
      default: m = ua % ub;
    endcase
    return m[31:0];
  endfunction
  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input bit hold_start, input string name);
    int lat, k;
    bit st_ok;
    lat = is_special(op, a, b) ? 1 : 33;
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== exp_hold) begin
      n_err++;
      $display("FAIL %s idle: busy=%b done=%b result=%h, need 0 0 %h", name, busy_o, done_o, result_o, exp_hold);
    end
    start_i = 1;
    op_i = op;
    reg1_data_i = a;
    reg2_data_i = b;
    write_addr_i = rd;
    #1;
    n_cmp++;
    if (stall_req_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s stall_at_start: got %b need 1", name, stall_req_o);
    end
    @(negedge clk);
    k = 1;
    st_ok = 1;
    if (!hold_start) start_i = 0;
    while (done_o !== 1'b1 && k < 40) begin
      if (stall_req_o !== 1'b1 || busy_o !== 1'b1) st_ok = 0;
      if (hold_start) begin
        op_i = 3'($urandom_range(0, 7));
        reg1_data_i = $urandom;
        reg2_data_i = $urandom;
        write_addr_i = 5'($urandom);
      end
      @(negedge clk);
      k++;
    end
    start_i = 0;
    n_cmp++;
    if (k != lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles need %0d", name, k, lat);
    end
    n_cmp++;
    if (result_o !== exp) begin
      n_err++;
      $display("FAIL %s result: got %h need %h", name, result_o, exp);
    end
    n_cmp++;
    if (write_addr_o !== rd) begin
      n_err++;
      $display("FAIL %s write_addr: got %0d need %0d", name, write_addr_o, rd);
    end
    n_cmp++;
    if (st_ok !== 1'b1 || stall_req_o !== 1'b0 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s handshake: calc_ok=%b stall=%b busy=%b, need 1 0 1", name, st_ok, stall_req_o, busy_o);
    end
    exp_hold = exp;
  endtask
  task automatic check_zero(input string name);
    n_cmp++;
    if ({busy_o, done_o, stall_req_o} !== 3'b000 || result_o !== 32'h0 || write_addr_o !== 5'h0) begin
      n_err++;
      $display("FAIL %s: busy=%b done=%b stall=%b result=%h waddr=%0d, need all 0", name, busy_o, done_o, stall_req_o, result_o, write_addr_o);
    end
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    check_zero("reset_asserted");
    rst = 0;
    @(negedge clk);
    check_zero("reset_released");
    exp_hold = '0;
  endtask
  task automatic test_mul;
    run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0, "mul");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 0, "mulh");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 0, "mulhu");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 0, "mulhsu");
  endtask
  task automatic test_div;
    run_op(3'b100, 32'hFFFF_FFF9, 32'h2, 5'd9, 32'hFFFF_FFFD, 0, "div_neg");
    run_op(3'b110, 32'hFFFF_FFF9, 32'h2, 5'd10, 32'hFFFF_FFFF, 0, "rem_neg");
    run_op(3'b101, 32'd100, 32'd7, 5'd11, 32'h0000_000E, 0, "divu");
    run_op(3'b111, 32'd100, 32'd7, 5'd12, 32'h0000_0002, 0, "remu");
  endtask
  task automatic test_back_to_back;
    run_op(3'b100, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 0, "div_by_zero");
    run_op(3'b110, 32'd5, 32'd0, 5'd14, 32'h0000_0005, 0, "rem_by_zero");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0, "div_overflow");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 0, "rem_overflow");
  endtask
  task automatic test_ignore_start;
    run_op(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17, ref_res(3'b000, 32'h1234_5678, 32'h9ABC_DEF0), 1, "mul_start_held");
  endtask
  task automatic test_flush;
    bit saw;
    @(negedge clk);
    start_i = 1;
    op_i = 3'b101;
    reg1_data_i = 32'd1000;
    reg2_data_i = 32'd7;
    write_addr_i = 5'd9;
    @(negedge clk);
    start_i = 0;
    repeat (9) @(negedge clk);
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    n_cmp++;
    if (busy_o !== 1'b0 || stall_req_o !== 1'b0 || done_o !== 1'b0 || result_o !== exp_hold) begin
      n_err++;
      $display("FAIL flush_abort: busy=%b stall=%b done=%b result=%h, need 0 0 0 %h", busy_o, stall_req_o, done_o, result_o, exp_hold);
    end
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o !== 1'b0) saw = 1;
    end
    n_cmp++;
    if (saw) begin
      n_err++;
      $display("FAIL flush_no_done: done_o pulsed after flush, need none");
    end
    run_op(3'b101, 32'd9, 32'd3, 5'd18, 32'h0000_0003, 0, "divu_after_flush");
  endtask
  task automatic test_reset_calc;
    @(negedge clk);
    start_i = 1;
    op_i = 3'b000;
    reg1_data_i = 32'hDEAD_BEEF;
    reg2_data_i = 32'h0BAD_F00D;
    write_addr_i = 5'd21;
    @(negedge clk);
    start_i = 0;
    repeat (19) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_zero("reset_in_calc");
    exp_hold = '0;
    @(negedge clk);
    check_zero("reset_in_calc_no_done");
  endtask
  task automatic test_random;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 15));
        default: ;
      endcase
      run_op(op, a, b, 5'($urandom), ref_res(op, a, b), 0, $sformatf("random%0d_op%0d", i, op));
    end
  endtask
  initial begin
    test_reset;
    test_mul;
    test_div;
    test_back_to_back;
    test_ignore_start;
    test_flush;
    test_reset_calc;
    test_random;
    @(negedge clk);
    n_cmp++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL final_idle: done=%b busy=%b need 0 0", done_o, busy_o);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
